// File: rtl/sd1_tb_pkg.sv
// Shared types and limits for the SD1 truth-table sweep checker.
// Holds the sweep FSM state encoding and the parameter legality rule.
package sd1_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FINISH = 2'd2
  } sweep_state_e;

  localparam int SWEEP_MIN_HOLD = 2;
  localparam int SWEEP_MIN_N_IN = 1;
  localparam int SWEEP_MAX_N_IN = 8;

  function automatic bit sweep_params_ok(
    input int n_in,
    input int hold
  );
    return (n_in >= SWEEP_MIN_N_IN) &&
           (n_in <= SWEEP_MAX_N_IN) &&
           (hold >= SWEEP_MIN_HOLD);
  endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// Per-vector hold counter for the truth-table sweeper.
// Counts 0..HOLD-1 while enabled; last flags the sample cycle.
module tt_hold_timer #(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2**N_IN input vectors into a combinational DUT,
// samples dut_f at the end of each hold and scores against EXPECT.
module tt_sweep_checker
  import sd1_tb_pkg::*;
#(
  parameter int                  N_IN   = 3,
  parameter int                  HOLD   = 10,
  parameter logic [2**N_IN-1:0]  EXPECT = 8'hE8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_f,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

  if (!sweep_params_ok(N_IN, HOLD)) begin : g_bad_params
    $error("tt_sweep_checker: N_IN must be 1..8 and HOLD >= 2");
  end

  sweep_state_e    state_q;
  sweep_state_e    state_d;
  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_next;
  logic [N_IN-1:0] fvec_q;
  logic            fvalid_q;
  logic            pass_q;
  logic            applying;
  logic            last;
  logic            sample;
  logic            mismatch;
  logic            last_vec;

  assign applying = (state_q == ST_APPLY);
  assign sample   = applying && last;
  assign mismatch = sample && (dut_f != EXPECT[vec_q]);
  assign last_vec = (vec_q == LAST_VEC);
  assign err_next = err_q + {{N_IN{1'b0}}, mismatch};

  tt_hold_timer #(
    .HOLD (HOLD)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!applying || last),
    .en    (applying),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        if (sample && last_vec) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Verdict is taken from err_next so a last-vector miss counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      err_q    <= '0;
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        vec_q    <= '0;
        err_q    <= '0;
        fvec_q   <= '0;
        fvalid_q <= 1'b0;
        pass_q   <= 1'b0;
      end else if (sample) begin
        err_q <= err_next;
        if (mismatch && !fvalid_q) begin
          fvec_q   <= vec_q;
          fvalid_q <= 1'b1;
        end
        if (last_vec) begin
          pass_q <= (err_next == '0);
        end else begin
          vec_q <= vec_q + 1'b1;
        end
      end
    end
  end

  assign stim            = applying ? vec_q : '0;
  assign busy            = applying;
  assign done            = (state_q == ST_FINISH);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_vec   = fvec_q;
  assign first_err_valid = fvalid_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: default majority build and a 4-input
// parity build, each driven by a model DUT with an injectable fault mask.
module tb_tt_sweep_checker;

  logic clk;
  logic rst_n;

  logic       start_a;
  logic       f_a;
  logic [2:0] stim_a;
  logic       busy_a;
  logic       done_a;
  logic       pass_a;
  logic [3:0] err_a;
  logic [2:0] fvec_a;
  logic       fvalid_a;

  logic       start_b;
  logic       f_b;
  logic [3:0] stim_b;
  logic       busy_b;
  logic       done_b;
  logic       pass_b;
  logic [4:0] err_b;
  logic [3:0] fvec_b;
  logic       fvalid_b;

  logic [7:0]  mask_a;
  logic [15:0] mask_b;

  int checks;
  int errors;

  tt_sweep_checker u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start_a),
    .dut_f           (f_a),
    .stim            (stim_a),
    .busy            (busy_a),
    .done            (done_a),
    .pass            (pass_a),
    .err_count       (err_a),
    .first_err_vec   (fvec_a),
    .first_err_valid (fvalid_a)
  );

  tt_sweep_checker #(
    .N_IN   (4),
    .HOLD   (2),
    .EXPECT (16'h6996)
  ) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start_b),
    .dut_f           (f_b),
    .stim            (stim_b),
    .busy            (busy_b),
    .done            (done_b),
    .pass            (pass_b),
    .err_count       (err_b),
    .first_err_vec   (fvec_b),
    .first_err_valid (fvalid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model DUTs: ideal function flipped wherever the fault mask is set.
  always_comb begin
    f_a = ($countones(stim_a) >= 2) ^ mask_a[stim_a];
    f_b = (^stim_b) ^ mask_b[stim_b];
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_sweep(input bit wide, input string tag);
    int nv;
    int hd;
    int done_edge;
    int done_n;
    int stim_bad;
    int busy_bad;
    int exp_err;
    int exp_first;
    int s;
    int b;
    logic [15:0] m;
    nv = wide ? 16 : 8;
    hd = wide ? 2 : 10;
    m  = wide ? mask_b : {8'h00, mask_a};
    exp_err   = 0;
    exp_first = -1;
    for (int v = 0; v < nv; v++) begin
      if (m[v]) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    end
    @(negedge clk);
    if (wide) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    done_edge = -1;
    done_n    = 0;
    stim_bad  = 0;
    busy_bad  = 0;
    for (int e = 0; e < nv * hd + 4; e++) begin
      s = wide ? int'(stim_b) : int'(stim_a);
      b = wide ? int'(busy_b) : int'(busy_a);
      if (s != ((e < nv * hd) ? e / hd : 0)) stim_bad++;
      if (b != ((e < nv * hd) ? 1 : 0)) busy_bad++;
      if (wide ? done_b : done_a) begin
        done_n++;
        if (done_edge < 0) done_edge = e;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_stim_seq"}, 32'(stim_bad), 0);
    chk({tag, "_busy_win"}, 32'(busy_bad), 0);
    chk({tag, "_done_edge"}, 32'(done_edge), 32'(nv * hd));
    chk({tag, "_done_cnt"}, 32'(done_n), 1);
    chk({tag, "_err"},
        wide ? 32'(err_b) : 32'(err_a), 32'(exp_err));
    chk({tag, "_pass"},
        wide ? 32'(pass_b) : 32'(pass_a), 32'(exp_err == 0));
    chk({tag, "_fvalid"},
        wide ? 32'(fvalid_b) : 32'(fvalid_a), 32'(exp_err != 0));
    if (exp_err != 0) begin
      chk({tag, "_fvec"},
          wide ? 32'(fvec_b) : 32'(fvec_a), 32'(exp_first));
    end
  endtask

  initial begin
    int done_n;
    int done_edge;
    int busy81;
    int busy82;
    int seen;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mask_a  = 8'h00;
    mask_b  = 16'h0000;
    #2;
    chk("rst_stim", 32'(stim_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_fvalid", 32'(fvalid_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mask_a = 8'h00;
    run_sweep(1'b0, "golden");
    mask_a = 8'hFF;
    run_sweep(1'b0, "inverted");
    mask_a = 8'h20;
    run_sweep(1'b0, "fault5");
    mask_a = 8'h80;
    run_sweep(1'b0, "fault7");
    for (int r = 0; r < 3; r++) begin
      mask_a = 8'($urandom);
      run_sweep(1'b0, $sformatf("rand_a%0d", r));
    end

    // start held high: one sweep, then a fresh one only via IDLE
    mask_a = 8'h00;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    done_n    = 0;
    done_edge = -1;
    busy81    = -1;
    busy82    = -1;
    for (int e = 0; e <= 82; e++) begin
      if (done_a) begin
        done_n++;
        if (done_edge < 0) done_edge = e;
      end
      if (e == 81) busy81 = int'(busy_a);
      if (e == 82) busy82 = int'(busy_a);
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;
    chk("held_done_cnt", 32'(done_n), 1);
    chk("held_done_edge", 32'(done_edge), 80);
    chk("held_idle_gap", 32'(busy81), 0);
    chk("held_restart", 32'(busy82), 1);
    seen = 0;
    for (int e = 0; e < 100 && seen == 0; e++) begin
      if (done_a) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("held_second_done", 32'(seen), 1);

    // async reset in the middle of vector 3
    mask_a = 8'h01;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("mid_stim", 32'(stim_a), 3);
    chk("mid_err", 32'(err_a), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stim", 32'(stim_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_err", 32'(err_a), 0);
    chk("arst_pass", 32'(pass_a), 0);
    chk("arst_fvalid", 32'(fvalid_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (busy_a || done_a) seen = 1;
    end
    chk("arst_stays_idle", 32'(seen), 0);

    mask_b = 16'h0000;
    run_sweep(1'b1, "parity");
    mask_b = 16'h6996;
    run_sweep(1'b1, "const0");
    for (int r = 0; r < 3; r++) begin
      mask_b = 16'($urandom);
      run_sweep(1'b1, $sformatf("rand_b%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
